// File: rtl/data_cache_wt_if.sv
// Memory-style request/response port shared by the core side and the backing-memory side
// of the write-through data cache.
interface data_cache_wt_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_do_read;
    logic [3:0]  req_do_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_addr;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_data, req_do_read, req_do_write,
        input  rsp_valid, rsp_ready, rsp_addr, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_do_read, req_do_write,
        output rsp_valid, rsp_ready, rsp_addr, rsp_data
    );
endinterface

// File: rtl/data_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with line refill on read miss.
// Optional hit/miss counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache_wt #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_cache_wt_if.slave     core,
    data_cache_wt_if.master    mem
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int WORD_BITS  = $clog2(LINE_WORDS);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int OFF_W      = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int LINE_SHIFT = 2 + WORD_BITS;
    localparam int TAG_SHIFT  = LINE_SHIFT + INDEX_BITS;
    localparam int TAG_W      = 32 - TAG_SHIFT;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REFILL_REQ,
        REFILL_WAIT,
        WRITE_REQ,
        WRITE_WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][LINE_WORDS];

    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [3:0]       req_wmask;
    logic [OFF_W-1:0] refill_k;
    logic [31:0]      rsp_data_q;

    logic [INDEX_BITS-1:0] in_index, req_index;
    logic [TAG_W-1:0]      in_tag, req_tag;
    logic [OFF_W-1:0]      in_off, req_off;
    logic                  accept, is_write, is_read, hit, refill_beat;
    logic [31:0]           wdata_shuf;
    logic [3:0]            wmask_shuf;

    assign in_index  = INDEX_BITS'(core.req_addr >> LINE_SHIFT);
    assign in_tag    = TAG_W'(core.req_addr >> TAG_SHIFT);
    assign in_off    = OFF_W'((core.req_addr >> 2) & 32'(LINE_WORDS - 1));
    assign req_index = INDEX_BITS'(req_addr >> LINE_SHIFT);
    assign req_tag   = TAG_W'(req_addr >> TAG_SHIFT);
    assign req_off   = OFF_W'((req_addr >> 2) & 32'(LINE_WORDS - 1));

    // Acceptance is decoded from state directly so it does not loop through rsp_ready.
    assign accept      = core.req_valid && (state == IDLE) && reset;
    assign is_write    = |core.req_do_write;
    assign is_read     = !is_write && (|core.req_do_read);
    assign hit         = valid_q[in_index] && (tag_q[in_index] == in_tag);
    assign refill_beat = (state == REFILL_WAIT) && mem.rsp_valid;
    assign wdata_shuf  = core.req_data << {core.req_addr[1:0], 3'b000};
    assign wmask_shuf  = 4'(core.req_do_write << core.req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are qualified with reset so nothing leaks out during the reset cycle.
    always_comb begin
        state_next        = state;
        core.rsp_ready    = 1'b0;
        core.rsp_valid    = 1'b0;
        core.rsp_addr     = req_addr;
        core.rsp_data     = rsp_data_q;
        mem.req_valid     = 1'b0;
        mem.req_addr      = 32'h0;
        mem.req_data      = 32'h0;
        mem.req_do_read   = 4'b0000;
        mem.req_do_write  = 4'b0000;
        case (state)
            IDLE: begin
                core.rsp_ready = reset;
                if (accept) begin
                    if (is_write) begin
                        state_next = WRITE_REQ;
                    end else if (is_read) begin
                        state_next = hit ? RESPOND : REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                mem.req_addr    = {req_addr[31:LINE_SHIFT], LINE_SHIFT'(0)} | (32'(refill_k) << 2);
                mem.req_do_read = 4'b1111;
                if (mem.rsp_ready) begin
                    mem.req_valid = reset;
                    state_next    = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (mem.rsp_valid) begin
                    state_next = (refill_k == LAST_WORD) ? RESPOND : REFILL_REQ;
                end
            end
            WRITE_REQ: begin
                mem.req_addr     = req_addr;
                mem.req_data     = req_wdata;
                mem.req_do_write = req_wmask;
                if (mem.rsp_ready) begin
                    mem.req_valid = reset;
                    state_next    = WRITE_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (mem.rsp_valid) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                core.rsp_valid = reset;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A missing line is invalidated at accept so a reset during refill leaves it unusable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
`ifdef DATA_CACHE_STATS_EN
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
`endif
        end else begin
            if (accept && is_read && !hit) begin
                valid_q[in_index] <= 1'b0;
            end
            if (refill_beat && (refill_k == LAST_WORD)) begin
                valid_q[req_index] <= 1'b1;
            end
`ifdef DATA_CACHE_STATS_EN
            if (accept && is_read) begin
                if (hit) begin
                    hit_count <= hit_count + 32'd1;
                end else begin
                    miss_count <= miss_count + 32'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (is_write || is_read)) begin
            req_addr  <= core.req_addr;
            req_wdata <= wdata_shuf;
            req_wmask <= wmask_shuf;
            refill_k  <= '0;
        end
        if (accept && is_read && hit) begin
            rsp_data_q <= data_q[in_index][in_off];
        end
        if (accept && is_write && hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_shuf[b]) begin
                    data_q[in_index][in_off][8*b +: 8] <= wdata_shuf[8*b +: 8];
                end
            end
        end
        if (refill_beat) begin
            data_q[req_index][refill_k] <= mem.rsp_data;
            refill_k <= refill_k + OFF_W'(1);
            if (refill_k == req_off) begin
                rsp_data_q <= mem.rsp_data;
            end
            if (refill_k == LAST_WORD) begin
                tag_q[req_index] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_wt.sv
// Randomized bench for data_cache_wt: behavioural memory plus line-residency model, one
// per-cycle compare process, and directed scenarios pinned with literal expectations.
module tb_data_cache_wt;
    localparam int SETS = 64;
    localparam int LW   = 4;
    localparam int LINE_BYTES = 4 * LW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_cache_wt_if core_bus();
    data_cache_wt_if mem_bus();

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    data_cache_wt #(.SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_bus),
        .mem   (mem_bus)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          is_read;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [int unsigned];
    mem_txn_t    exp_mem [$];
    rsp_t        exp_rsp [$];
    bit          res_valid [SETS];
    int unsigned res_line  [SETS];
    int          model_hits = 0;
    int          model_misses = 0;

    int          mem_lat = 1;
    bit          stall_random = 1'b0;
    int          hold_ready_low = 0;
    int          issue_count = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data, pend_addr;
    logic [31:0] last_wr_data, last_wr_mask;

    bit          busy = 1'b0;
    bit          rsp_seen = 1'b0;
    logic [31:0] last_rsp_data;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int unsigned key;
        key = a >> 2;
        if (mem_words.exists(key)) return mem_words[key];
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Backing memory: one outstanding request, fixed latency, optional ready stalls.
    always begin
        @(negedge clk);
        mem_bus.rsp_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_bus.rsp_valid = 1'b1;
                mem_bus.rsp_data  = pend_data;
                mem_bus.rsp_addr  = pend_addr;
            end
        end
        if (hold_ready_low > 0) begin
            mem_bus.rsp_ready = 1'b0;
            hold_ready_low--;
        end else if (stall_random) begin
            mem_bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end else begin
            mem_bus.rsp_ready = 1'b1;
        end
        #1;
        check_output("mem_valid_without_ready", 32'(mem_bus.req_valid && !mem_bus.rsp_ready), 32'h0);
        if (mem_bus.req_valid && mem_bus.rsp_ready) begin
            mem_txn_t t;
            logic [31:0] w;
            issue_count++;
            if (exp_mem.size() == 0) begin
                check_output("unexpected_mem_req", mem_bus.req_addr, 32'hFFFF_FFFF);
            end else begin
                t = exp_mem.pop_front();
                check_output("mem_addr", mem_bus.req_addr, t.addr);
                check_output("mem_do_read", 32'(mem_bus.req_do_read), 32'(t.rd));
                check_output("mem_do_write", 32'(mem_bus.req_do_write), 32'(t.wr));
                if (t.wr != 4'b0000) check_output("mem_wdata", mem_bus.req_data, t.data);
            end
            if (mem_bus.req_do_write != 4'b0000) begin
                w = mem_read(mem_bus.req_addr);
                for (int b = 0; b < 4; b++) begin
                    if (mem_bus.req_do_write[b]) w[8*b +: 8] = mem_bus.req_data[8*b +: 8];
                end
                mem_words[mem_bus.req_addr >> 2] = w;
                last_wr_data = mem_bus.req_data;
                last_wr_mask = 32'(mem_bus.req_do_write);
            end
            pend_cnt  = mem_lat;
            pend_data = mem_read(mem_bus.req_addr);
            pend_addr = mem_bus.req_addr;
        end
    end

    // Per-cycle core-side compare against the model's expected responses and busy state.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            check_output("core_ready", 32'(core_bus.rsp_ready), 32'(!busy));
            if (core_bus.rsp_valid) begin
                rsp_t r;
                if (exp_rsp.size() == 0) begin
                    check_output("unexpected_core_rsp", core_bus.rsp_addr, 32'hFFFF_FFFF);
                end else begin
                    r = exp_rsp.pop_front();
                    check_output("rsp_addr", core_bus.rsp_addr, r.addr);
                    if (r.is_read) check_output("rsp_data", core_bus.rsp_data, r.data);
                end
                last_rsp_data = core_bus.rsp_data;
                rsp_seen = 1'b1;
                busy = 1'b0;
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b0;
        core_bus.req_valid = 1'b0;
        exp_mem.delete();
        exp_rsp.delete();
        for (int i = 0; i < SETS; i++) res_valid[i] = 1'b0;
        model_hits = 0;
        model_misses = 0;
        busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check_output("reset_core_ready", 32'(core_bus.rsp_ready), 32'h0);
            check_output("reset_core_valid", 32'(core_bus.rsp_valid), 32'h0);
            check_output("reset_mem_valid", 32'(mem_bus.req_valid), 32'h0);
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic check_stats();
`ifdef DATA_CACHE_STATS_EN
        check_output("hit_count", hit_count, 32'(model_hits));
        check_output("miss_count", miss_count, 32'(model_misses));
`endif
    endtask

    task automatic apply_stimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] mask, input bit check_lat, input int abort_after);
        int          n, lat, exp_lat, exp_words, start_issues;
        int unsigned line, idx;
        bit          hit, aborted;
        logic [3:0]  sm;
        logic [31:0] sd;
        n = 0;
        while (core_bus.rsp_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("core_ready_timeout", 32'(n >= 200), 32'h0);
        line = addr / LINE_BYTES;
        idx  = line % SETS;
        start_issues = issue_count;
        if (!is_write) begin
            hit = res_valid[idx] && (res_line[idx] == line);
            if (hit) begin
                model_hits++;
                exp_words = 0;
                exp_lat = 1;
            end else begin
                model_misses++;
                for (int k = 0; k < LW; k++) begin
                    exp_mem.push_back('{line * LINE_BYTES + 4 * k, 4'b1111, 4'b0000, 32'h0});
                end
                res_valid[idx] = 1'b1;
                res_line[idx]  = line;
                exp_words = LW;
                exp_lat = 1 + (mem_lat + 1) * LW;
            end
            exp_rsp.push_back('{addr, mem_read(addr), 1'b1});
        end else begin
            sm = 4'(mask << addr[1:0]);
            sd = wdata << (8 * addr[1:0]);
            exp_mem.push_back('{addr, 4'b0000, sm, sd});
            exp_rsp.push_back('{addr, 32'h0, 1'b0});
            exp_words = 1;
            exp_lat = 2 + mem_lat;
        end
        rsp_seen = 1'b0;
        core_bus.req_valid    = 1'b1;
        core_bus.req_addr     = addr;
        core_bus.req_data     = is_write ? wdata : $urandom;
        core_bus.req_do_write = is_write ? mask : 4'b0000;
        core_bus.req_do_read  = (is_write && $urandom_range(0, 1) == 0) ? 4'b0000 : 4'(4'b1111 << addr[1:0]);
        @(posedge clk);
        busy = 1'b1;
        @(negedge clk);
        core_bus.req_valid = 1'b0;
        lat = 0;
        aborted = 1'b0;
        forever begin
            #2;
            lat++;
            if (abort_after > 0 && (issue_count - start_issues) >= abort_after) begin
                do_reset(3);
                aborted = 1'b1;
                break;
            end
            if (rsp_seen || lat > 2000) break;
            @(negedge clk);
        end
        if (!aborted) begin
            check_output("rsp_timeout", 32'(rsp_seen), 32'h1);
            if (check_lat) check_output("latency", 32'(lat), 32'(exp_lat));
            check_output("mem_issue_count", 32'(issue_count - start_issues), 32'(exp_words));
            check_output("mem_queue_drained", 32'(exp_mem.size()), 32'h0);
            check_stats();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] bases [7];
        logic [31:0] a;
        int          sz;
        core_bus.req_valid    = 1'b0;
        core_bus.req_addr     = 32'h0;
        core_bus.req_data     = 32'h0;
        core_bus.req_do_read  = 4'b0000;
        core_bus.req_do_write = 4'b0000;
        mem_bus.rsp_valid = 1'b0;
        mem_bus.rsp_ready = 1'b1;
        mem_bus.rsp_addr  = 32'h0;
        mem_bus.rsp_data  = 32'h0;
        mem_words[32'h100 >> 2] = 32'hDEAD_BEEF;

        @(negedge clk);
        do_reset(3);
        check_stats();

        $display("[TB] read miss then hit");
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 0);
        check_output("t1_data", last_rsp_data, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 32'h104, 32'h0, 4'b0000, 1'b1, 0);

        $display("[TB] store byte into cached line");
        apply_stimulus(1'b1, 32'h102, 32'h0000_00AA, 4'b0001, 1'b1, 0);
        check_output("t2_wmask", last_wr_mask, 32'h4);
        check_output("t2_wdata", last_wr_data, 32'h00AA_0000);
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 0);
        check_output("t2_merged", last_rsp_data, 32'hDEAA_BEEF);

        $display("[TB] no write allocate");
        apply_stimulus(1'b1, 32'h200, 32'h1122_3344, 4'b1111, 1'b1, 0);
        apply_stimulus(1'b0, 32'h200, 32'h0, 4'b0000, 1'b1, 0);
        check_output("t3_data", last_rsp_data, 32'h1122_3344);

        $display("[TB] conflict eviction");
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 0);
        apply_stimulus(1'b0, 32'h100 + LINE_BYTES * SETS, 32'h0, 4'b0000, 1'b1, 0);
        apply_stimulus(1'b0, 32'h100, 32'h0, 4'b0000, 1'b1, 0);
        check_output("t4_data", last_rsp_data, 32'hDEAA_BEEF);

        $display("[TB] memory backpressure during refill");
        hold_ready_low = 5;
        apply_stimulus(1'b0, 32'h304, 32'h0, 4'b0000, 1'b0, 0);

        $display("[TB] reset mid refill");
        apply_stimulus(1'b0, 32'h400, 32'h0, 4'b0000, 1'b0, 2);
        check_stats();
        apply_stimulus(1'b0, 32'h400, 32'h0, 4'b0000, 1'b1, 0);
`ifdef DATA_CACHE_STATS_EN
        check_output("t6_miss_count", miss_count, 32'h1);
        check_output("t6_hit_count", hit_count, 32'h0);
`endif

        $display("[TB] randomized traffic");
        bases[0] = 32'h100;
        bases[1] = 32'h100 + LINE_BYTES * SETS;
        bases[2] = 32'h200;
        bases[3] = 32'h0;
        bases[4] = LINE_BYTES * (SETS - 1);
        bases[5] = LINE_BYTES * (SETS - 1) + LINE_BYTES * SETS;
        bases[6] = 32'hABC0;
        for (int i = 0; i < 200; i++) begin
            stall_random = ($urandom_range(0, 3) == 0);
            mem_lat = $urandom_range(1, 3);
            a = bases[$urandom_range(0, 6)] + 4 * $urandom_range(0, LW - 1);
            if ($urandom_range(0, 2) == 0) begin
                sz = $urandom_range(0, 2);
                if (sz == 0) begin
                    a = a + $urandom_range(0, 3);
                    apply_stimulus(1'b1, a, $urandom, 4'b0001, !stall_random, 0);
                end else if (sz == 1) begin
                    a = a + 2 * $urandom_range(0, 1);
                    apply_stimulus(1'b1, a, $urandom, 4'b0011, !stall_random, 0);
                end else begin
                    apply_stimulus(1'b1, a, $urandom, 4'b1111, !stall_random, 0);
                end
            end else begin
                apply_stimulus(1'b0, a + $urandom_range(0, 3), 32'h0, 4'b0000, !stall_random, 0);
            end
        end
        stall_random = 1'b0;
        repeat (5) @(negedge clk);
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
